// File: rtl/pb_led_pkg.sv
// Shared types and helpers for the push-button LED pattern generator.
package pb_led_pkg;

    localparam int unsigned SW_W   = 2;
    localparam int unsigned BTN_W  = 4;
    localparam int unsigned LED_W  = 4;
    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_PASS  = 2'd0,
        MODE_SHR2  = 2'd1,
        MODE_ROTL3 = 2'd2,
        MODE_INV   = 2'd3
    } mode_e;

    // Thermometer base pattern selected by the slide switches.
    function automatic logic [LED_W-1:0] base_pattern(input logic [SW_W-1:0] sw);
        logic [LED_W-1:0] pat;
        case (sw)
            2'b00:   pat = 4'b0001;
            2'b01:   pat = 4'b0011;
            2'b10:   pat = 4'b0111;
            default: pat = 4'b1111;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/pb_led_xform.sv
// Combinational transform of the base pattern by the latched mode.
module pb_led_xform
    import pb_led_pkg::*;
(
    input  logic [LED_W-1:0] base,
    input  mode_e            mode,
    output logic [LED_W-1:0] out
);

    // Select one of the four fixed transforms.
    always_comb begin
        out = base;
        case (mode)
            MODE_PASS:  out = base;
            MODE_SHR2:  out = base >> 2;
            MODE_ROTL3: out = {base[0], base[3:1]};
            MODE_INV:   out = ~base;
            default:    out = base;
        endcase
    end

endmodule

// File: rtl/pb_led_mode_xform.sv
// LED pattern generator: switches pick a base pattern, buttons latch a transform mode.
module pb_led_mode_xform
    import pb_led_pkg::*;
(
    input  logic             clk_125,
    input  logic             rst,
    input  logic [SW_W-1:0]  sw,
    input  logic [BTN_W-1:0] btn,
    output logic [LED_W-1:0] led
);

    mode_e            mode_q;
    mode_e            mode_nxt_c;
    logic [LED_W-1:0] base_c;
    logic [LED_W-1:0] xform_c;

    // Highest pressed button wins; no press keeps the current mode.
    always_comb begin
        mode_nxt_c = mode_q;
        if (btn[3])      mode_nxt_c = MODE_INV;
        else if (btn[2]) mode_nxt_c = MODE_ROTL3;
        else if (btn[1]) mode_nxt_c = MODE_SHR2;
        else if (btn[0]) mode_nxt_c = MODE_PASS;
    end

    assign base_c = base_pattern(sw);

    pb_led_xform u_xform (
        .base (base_c),
        .mode (mode_q),
        .out  (xform_c)
    );

    // Mode and LED registers; led uses the mode latched on the previous edge.
    always_ff @(posedge clk_125) begin
        if (rst) begin
            mode_q <= MODE_PASS;
            led    <= '0;
        end else begin
            mode_q <= mode_nxt_c;
            led    <= xform_c;
        end
    end

endmodule

// File: tb/tb_pb_led_mode_xform.sv
// Self-checking bench for pb_led_mode_xform: directed plan plus random stimulus.
module tb_pb_led_mode_xform;

    logic       clk_125 = 1'b0;
    logic       rst;
    logic [1:0] sw;
    logic [3:0] btn;
    logic [3:0] led;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    int         m_mode = 0;
    logic [3:0] m_led  = 4'b0000;

    pb_led_mode_xform dut (
        .clk_125 (clk_125),
        .rst     (rst),
        .sw      (sw),
        .btn     (btn),
        .led     (led)
    );

    always #4 clk_125 = ~clk_125;

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Reference transform straight from the arithmetic definitions.
    function automatic logic [3:0] ref_xf(input int s, input int m);
        int b;
        int r;
        b = (1 << (s + 1)) - 1;
        case (m)
            0:       r = b;
            1:       r = b >> 2;
            2:       r = ((b << 3) | (b >> 1)) & 15;
            default: r = 15 - b;
        endcase
        return 4'(r);
    endfunction

    // One clock: drive on falling edge, update model at rising edge, compare after it.
    task automatic cycle(input logic r, input logic [1:0] s, input logic [3:0] b, input string tag);
        @(negedge clk_125);
        rst = r;
        sw  = s;
        btn = b;
        @(posedge clk_125);
        if (r) begin
            m_mode = 0;
            m_led  = 4'b0000;
        end else begin
            m_led = ref_xf(int'(s), m_mode);
            for (int k = 0; k < 4; k++)
                if (b[k]) m_mode = k;
        end
        #1;
        check_val(tag, led, m_led);
    endtask

    task automatic cycle_exp(input logic r, input logic [1:0] s, input logic [3:0] b,
                             input string tag, input logic [3:0] exp);
        cycle(r, s, b, tag);
        check_val({tag, "_tbl"}, led, exp);
    endtask

    initial begin
        logic [3:0] tbl1 [4];
        logic [3:0] tbl2 [4];
        logic [3:0] tbl3 [4];
        logic [3:0] tbl0 [4];
        tbl0 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        tbl1 = '{4'b0000, 4'b0000, 4'b0001, 4'b0011};
        tbl2 = '{4'b1000, 4'b1001, 4'b1011, 4'b1111};
        tbl3 = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};

        rst = 1'b1;
        sw  = 2'b11;
        btn = 4'b1111;

        // Reset dominates buttons.
        for (int i = 0; i < 3; i++) cycle_exp(1'b1, 2'b11, 4'b1111, "reset", 4'b0000);
        cycle_exp(1'b0, 2'b00, 4'b0000, "reset_release", 4'b0001);

        // Mode 0 sweep.
        cycle(1'b0, 2'b00, 4'b0001, "m0_pulse");
        for (int s = 0; s < 4; s++) cycle_exp(1'b0, 2'(s), 4'b0000, "m0_sweep", tbl0[s]);

        // Mode 1 sweep.
        cycle(1'b0, 2'b11, 4'b0010, "m1_pulse");
        for (int s = 0; s < 4; s++) cycle_exp(1'b0, 2'(s), 4'b0000, "m1_sweep", tbl1[s]);

        // Mode 2 sweep.
        cycle(1'b0, 2'b11, 4'b0100, "m2_pulse");
        for (int s = 0; s < 4; s++) cycle_exp(1'b0, 2'(s), 4'b0000, "m2_sweep", tbl2[s]);

        // Mode 3 sweep.
        cycle(1'b0, 2'b11, 4'b1000, "m3_pulse");
        for (int s = 0; s < 4; s++) cycle_exp(1'b0, 2'(s), 4'b0000, "m3_sweep", tbl3[s]);

        // Priority: btn=1101 picks mode 3, visible one edge later.
        cycle_exp(1'b0, 2'b10, 4'b0001, "prio_setup", 4'b1000);
        cycle_exp(1'b0, 2'b10, 4'b1101, "prio_press", 4'b0111);
        cycle_exp(1'b0, 2'b10, 4'b0000, "prio_result", 4'b1000);

        // Back-to-back presses each latched in order.
        cycle(1'b0, 2'b10, 4'b0001, "b2b_0");
        cycle_exp(1'b0, 2'b10, 4'b0010, "b2b_1", 4'b0111);
        cycle_exp(1'b0, 2'b10, 4'b0100, "b2b_2", 4'b0001);
        cycle_exp(1'b0, 2'b10, 4'b0010, "b2b_3", 4'b1011);
        cycle_exp(1'b0, 2'b10, 4'b0000, "b2b_4", 4'b0001);

        // Held button re-latches same mode with steady output.
        cycle(1'b0, 2'b11, 4'b0100, "hold_arm");
        for (int i = 0; i < 4; i++) cycle_exp(1'b0, 2'b11, 4'b0100, "hold", 4'b1111);
        cycle_exp(1'b0, 2'b11, 4'b0000, "hold_release", 4'b1111);
        cycle_exp(1'b0, 2'b11, 4'b1000, "hold_m3_press", 4'b1111);
        cycle_exp(1'b0, 2'b11, 4'b0000, "hold_m3_result", 4'b0000);

        // Mid-operation reset discards mode.
        cycle_exp(1'b1, 2'b01, 4'b0000, "midrst", 4'b0000);
        cycle_exp(1'b0, 2'b01, 4'b0000, "midrst_after", 4'b0011);

        // Random stimulus against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic       r;
            logic [1:0] s;
            logic [3:0] b;
            r = ($urandom_range(0, 19) == 0);
            s = 2'($urandom_range(0, 3));
            b = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            cycle(r, s, b, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
